// File: rtl/hilo_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : hilo_unit_pkg                                               |
// | Purpose  : Shared definitions for the HI/LO multiply-divide unit:     |
// |            default widths, the zero word, opcode constants and the    |
// |            control FSM state type.                                    |
// | Ports    : none (package)                                             |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
package hilo_unit_pkg;

    localparam int unsigned HILO_W   = 32;
    localparam int unsigned HILO_OPW = 3;

    localparam logic [HILO_W-1:0] ZeroWord = '0;

    // Opcodes; 0 and 7 are both no-operations
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_NOP7  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } hilo_state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : hilo_unit_if                                                |
// | Purpose  : Request/response bundle of the HI/LO unit.                 |
// | Signals  : flush, op_valid, op, src_a, src_b, rd_sel (requester->unit)|
// |            busy, done, rd_data, hilo            (unit->requester)     |
// | Modports : master (requester side), slave (unit side)                 |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface hilo_unit_if
    import hilo_unit_pkg::*;
#(
    parameter int W   = HILO_W,
    parameter int OPW = HILO_OPW
);
    logic             flush;
    logic             op_valid;
    logic [OPW-1:0]   op;
    logic [W-1:0]     src_a;
    logic [W-1:0]     src_b;
    logic             rd_sel;
    logic             busy;
    logic             done;
    logic [W-1:0]     rd_data;
    logic [2*W-1:0]   hilo;

    modport master (
        output flush, op_valid, op, src_a, src_b, rd_sel,
        input  busy, done, rd_data, hilo
    );

    modport slave (
        input  flush, op_valid, op, src_a, src_b, rd_sel,
        output busy, done, rd_data, hilo
    );
endinterface
`default_nettype wire

// File: rtl/hilo_div.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : hilo_div                                                    |
// | Purpose  : Iterative restoring radix-2 divider, one quotient bit per  |
// |            cycle over operand magnitudes, with signed fixup.          |
// | Ports    : clk, rst (async active-low)                                |
// |            start_i, dividend_i, divisor_i, signed_i, abort_i          |
// |            quotient_o, remainder_o, valid_o                           |
// | Notes    : valid_o is high during the last iteration cycle; results   |
// |            are combinational then and meant to be captured on the     |
// |            edge that ends that cycle. Latency is W cycles after start.|
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module hilo_div #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         start_i,
    input  wire logic [W-1:0] dividend_i,
    input  wire logic [W-1:0] divisor_i,
    input  wire logic         signed_i,
    input  wire logic         abort_i,
    output logic [W-1:0]      quotient_o,
    output logic [W-1:0]      remainder_o,
    output logic              valid_o
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic          run_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;      // dividend bits shift out, quotient bits shift in
    logic [W-1:0]  dvs_q;
    logic          negq_q;
    logic          negr_q;

    logic          w_a_neg;
    logic          w_b_neg;
    logic [W-1:0]  w_a_mag;
    logic [W-1:0]  w_b_mag;
    logic [W:0]    w_rem_sh;
    logic          w_ge;
    logic [W-1:0]  w_sub;
    logic [W-1:0]  w_rem_n;
    logic [W-1:0]  w_quo_n;
    logic          w_last;

    assign w_a_neg = signed_i & dividend_i[W-1];
    assign w_b_neg = signed_i & divisor_i[W-1];
    assign w_a_mag = w_a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign w_b_mag = w_b_neg ? (~divisor_i + 1'b1) : divisor_i;

    // One restoring step. The compare is done on W+1 bits so a zero divisor
    // always "fits": quotient becomes all ones and the remainder ends up
    // holding the shifted-through dividend.
    assign w_rem_sh = {rem_q, quo_q[W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, dvs_q});
    assign w_sub    = w_rem_sh[W-1:0] - dvs_q;
    assign w_rem_n  = w_ge ? w_sub : w_rem_sh[W-1:0];
    assign w_quo_n  = {quo_q[W-2:0], w_ge};

    assign w_last      = run_q & (cnt_q == CW'(W-1));
    assign valid_o     = w_last & ~abort_i;
    assign quotient_o  = negq_q ? (~w_quo_n + 1'b1) : w_quo_n;
    assign remainder_o = negr_q ? (~w_rem_n + 1'b1) : w_rem_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (start_i) begin
            run_q  <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= w_a_mag;
            dvs_q  <= w_b_mag;
            // Divide by zero keeps the all-ones quotient unsigned-looking
            negq_q <= (w_a_neg ^ w_b_neg) & (|divisor_i);
            negr_q <= w_a_neg;
        end else if (run_q) begin
            if (abort_i || w_last) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                rem_q <= w_rem_n;
                quo_q <= w_quo_n;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : hilo_unit                                                   |
// | Purpose  : HI/LO register pair with single-cycle multiply, move-to    |
// |            HI/LO and a W-cycle iterative divide (hilo_div).           |
// | Ports    : clk, rst (async active-low), bus (hilo_unit_if.slave)      |
// | Config   : HILO_BYPASS_EN - forward a pending MULT/MULTU/MTHI/MTLO    |
// |            result to rd_data in its accept cycle.                     |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int W   = HILO_W,
    parameter int OPW = HILO_OPW
) (
    input  wire logic  clk,
    input  wire logic  rst,
    hilo_unit_if.slave bus
);
    hilo_state_e  state_q, state_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic         done_q, done_d;

    logic           w_accept;
    logic           w_op_mult, w_op_multu, w_op_div, w_op_divu, w_op_mthi, w_op_mtlo;
    logic [2*W-1:0] w_prod_s;
    logic [2*W-1:0] w_prod_u;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic           w_div_valid;

    assign w_op_mult  = (bus.op == OPW'(OP_MULT));
    assign w_op_multu = (bus.op == OPW'(OP_MULTU));
    assign w_op_div   = (bus.op == OPW'(OP_DIV));
    assign w_op_divu  = (bus.op == OPW'(OP_DIVU));
    assign w_op_mthi  = (bus.op == OPW'(OP_MTHI));
    assign w_op_mtlo  = (bus.op == OPW'(OP_MTLO));

    // A flush in the same cycle drops the request
    assign w_accept = bus.op_valid & ~bus.flush & (state_q == ST_IDLE);

    // Low 2W bits of the product of sign-extended operands is the signed product
    assign w_prod_s = {{W{bus.src_a[W-1]}}, bus.src_a} * {{W{bus.src_b[W-1]}}, bus.src_b};
    assign w_prod_u = {{W{1'b0}}, bus.src_a} * {{W{1'b0}}, bus.src_b};

    hilo_div #(.W(W)) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_accept & (w_op_div | w_op_divu)),
        .dividend_i  (bus.src_a),
        .divisor_i   (bus.src_b),
        .signed_i    (w_op_div),
        .abort_i     (bus.flush),
        .quotient_o  (w_quo),
        .remainder_o (w_rem),
        .valid_o     (w_div_valid)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_op_mult) begin
                        {hi_d, lo_d} = w_prod_s;
                        done_d       = 1'b1;
                    end else if (w_op_multu) begin
                        {hi_d, lo_d} = w_prod_u;
                        done_d       = 1'b1;
                    end else if (w_op_mthi) begin
                        hi_d   = bus.src_a;
                        done_d = 1'b1;
                    end else if (w_op_mtlo) begin
                        lo_d   = bus.src_a;
                        done_d = 1'b1;
                    end else if (w_op_div || w_op_divu) begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (w_div_valid) begin
                    hi_d    = w_rem;
                    lo_d    = w_quo;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == ST_DIV);
    assign bus.done = done_q;
    assign bus.hilo = {hi_q, lo_q};

`ifdef HILO_BYPASS_EN
    logic w_fwd;
    // Only single-cycle writers forward; the divide result is never bypassed
    assign w_fwd = w_accept & (w_op_mult | w_op_multu | w_op_mthi | w_op_mtlo);
    assign bus.rd_data = bus.rd_sel ? (w_fwd ? hi_d : hi_q) : (w_fwd ? lo_d : lo_q);
`else
    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
`endif
endmodule
`default_nettype wire
